gpio_input_conditioner: RTL and testbench
=========================================

Name: gpio_input_conditioner

Overview:
Parametrised, multi-channel front end for the board GPIO header. It replaces raw, unsynchronised `gpio1` bits with debounced levels, per-channel edge pulses and sticky event flags that the CPU can mask and clear. It sits between the top-level `gpio1` pins and the CPU I/O path. Its `irq` output gives a single maskable "button event" signal in place of polling raw pins.

Parameters:
- CHANNELS, 36, number of GPIO input bits conditioned (matches the `gpio1` width).
- DEBOUNCE_CYCLES, 500000, consecutive stable clocks required to accept a new level. At 50 MHz this is 10 ms. Minimum legal value is 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each per-channel counter. Derived; not overridden.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-low reset.
- gpio_in  input  CHANNELS  raw pin levels, asynchronous to clk.
- level  output  CHANNELS  debounced level per channel.
- rise_pulse  output  CHANNELS  one-clock pulse on a debounced 0→1 transition.
- fall_pulse  output  CHANNELS  one-clock pulse on a debounced 1→0 transition.
- pending  output  CHANNELS  sticky event flags.
- evt_clr  input  CHANNELS  write-1-to-clear strobe for `pending`.
- mask_we  input  1  load strobe for the interrupt mask.
- mask_wdata  input  CHANNELS  new interrupt mask value.
- irq_mask  output  CHANNELS  current interrupt mask.
- irq  output  1  OR-reduction of (pending & irq_mask).

Behaviour:
- Reset (rst=0, asynchronous, no clock needed): synchronisers, level, counters, rise_pulse, fall_pulse, pending, irq_mask and irq all go to 0.
- Synchroniser: two flops per channel, giving `sync`.
- Debounce, per channel:
  - sync == level: counter <= 0.
  - sync != level and counter == DEBOUNCE_CYCLES-1: level <= sync, counter <= 0.
  - sync != level otherwise: counter <= counter+1.
  - Any return to sync == level before terminal count restarts the count. Glitches shorter than DEBOUNCE_CYCLES clocks are rejected.
  - DEBOUNCE_CYCLES=1: level follows sync with one clock of delay.
- Latency: a clean pin edge first shows on `level` 2+DEBOUNCE_CYCLES clocks after the first clk edge that samples it.
- Edges:
  - rise_pulse = 1 for exactly the first clock on which the new level=1 is visible.
  - fall_pulse behaves the same way for level=0.
  - Both are registered from level transitions.
- Pending:
  - Set on the clock after rise_pulse (and fall_pulse, see Optional Feature).
  - Cleared on the clock after evt_clr bit=1.
  - Set and clear on the same clock: set wins, so pending stays 1.
  - evt_clr on a clear bit has no effect.
- Mask: irq_mask <= mask_wdata on a clock with mask_we=1; otherwise it holds.
- irq: registered, equal to |(pending & irq_mask) as of the previous clock. It follows a mask or pending change by one clock.
- Counters never wrap; the terminal-count compare prevents overflow.
- Reset asserted mid-count: the count is discarded, and no edge or pending is generated on release.

Optional Feature:
- Macro: GPIO_FALL_EDGE_EN.
- Defined: fall_pulse also sets pending, so both press and release become events.
- Undefined: only rise_pulse sets pending. fall_pulse is still generated.

Decomposition:
- Package `gpio_pkg`: default CHANNELS, the default DEBOUNCE_CYCLES constant (CLK_HZ/100), and the CLK_HZ=50_000_000 constant.
- Sub-module `gpio_debounce_ch`: one channel covering the synchroniser, counter, level register and rise/fall pulse registers. It is generated CHANNELS times.
- Top level holds: pending, mask and irq logic.

Test Plan:
Benches run with DEBOUNCE_CYCLES=4 and CHANNELS=36.
1. Reset:
   - Stimulus: hold rst=0 while toggling gpio_in.
   - Response: all outputs stay 0. After release with gpio_in=0, outputs remain 0.
2. Clean press:
   - Stimulus: gpio_in[25] 0→1, held 20 clocks.
   - Response: level[25]=1 exactly 6 clocks after the sampling edge; rise_pulse[25] high for one clock; pending[25]=1 one clock later; irq=0 because the mask is 0.
3. Glitch rejection:
   - Stimulus: gpio_in[25] high for 3 clocks, then low.
   - Response: level, rise_pulse and pending on channel 25 never change.
4. Mask and clear:
   - Stimulus: with pending[25]=1, load mask_wdata bit 25 via mask_we.
   - Response: irq=1 one clock later. evt_clr[25]=1 → pending[25]=0, then irq=0 one clock later.
   - Stimulus: evt_clr[25] on the same clock as a new rise.
   - Response: pending[25] remains 1.
5. Release, run twice:
   - Stimulus: gpio_in[25] 1→0, held.
   - Response, both builds: fall_pulse[25] pulses 6 clocks after the sampling edge.
   - Response, GPIO_FALL_EDGE_EN defined: pending[25] is set.
   - Response, GPIO_FALL_EDGE_EN undefined: pending[25] stays 0.
6. Async reset mid-debounce:
   - Stimulus: with the channel 25 counter at 2, drive rst=0 between clk edges.
   - Response: all state is 0 before the next edge. After release with gpio_in[25] still 1, a full 6-clock latency restarts.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input conditioner: clock rate and default geometry.
package gpio_pkg;

  localparam int CLK_HZ              = 50_000_000;
  localparam int CHANNELS_DEF        = 36;
  localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;

endpackage

// File: rtl/gpio_debounce_ch.sv
// One GPIO channel: two-flop synchroniser, stability counter, debounced level
// and registered rise/fall pulses.
module gpio_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic             w_diff;
  logic             w_term;

  assign w_diff = r_sync_p1 ^ r_level;
  assign w_term = w_diff && (r_cnt == TERM);

  // Synchroniser stage, then debounce/edge stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_sync_p0 <= i_pin;
      r_sync_p1 <= r_sync_p0;
      if (!w_diff || w_term) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_term) begin
        r_level <= r_sync_p1;
      end
      r_rise <= w_term & r_sync_p1;
      r_fall <= w_term & ~r_sync_p1;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner top: per-channel debouncers plus sticky pending flags,
// interrupt mask and registered irq. Define GPIO_FALL_EDGE_EN to let releases set pending too.
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int CHANNELS        = CHANNELS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] gpio_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] pending,
  input  logic [CHANNELS-1:0] evt_clr,
  input  logic                mask_we,
  input  logic [CHANNELS-1:0] mask_wdata,
  output logic [CHANNELS-1:0] irq_mask,
  output logic                irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CHANNELS-1:0] w_level;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_fall;
  logic [CHANNELS-1:0] w_set;
  logic [CHANNELS-1:0] r_pending;
  logic [CHANNELS-1:0] r_mask;
  logic                r_irq;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    gpio_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .i_clk  (clk),
      .i_rst_n(rst),
      .i_pin  (gpio_in[g]),
      .o_level(w_level[g]),
      .o_rise (w_rise[g]),
      .o_fall (w_fall[g])
    );
  end

`ifdef GPIO_FALL_EDGE_EN
  assign w_set = w_rise | w_fall;
`else
  assign w_set = w_rise;
`endif

  // Event stage: set has priority over a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~evt_clr) | w_set;
      if (mask_we) begin
        r_mask <= mask_wdata;
      end
      r_irq <= |(r_pending & r_mask);
    end
  end

  assign level      = w_level;
  assign rise_pulse = w_rise;
  assign fall_pulse = w_fall;
  assign pending    = r_pending;
  assign irq_mask   = r_mask;
  assign irq        = r_irq;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Scoreboard bench for gpio_input_conditioner (CHANNELS=36, DEBOUNCE_CYCLES=4).
module tb_gpio_input_conditioner;

  localparam int CH  = 36;
  localparam int DB  = 4;
  localparam int LAT = 2 + DB;
  localparam int B   = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] gpio_in;
  logic [CH-1:0] level;
  logic [CH-1:0] rise_pulse;
  logic [CH-1:0] fall_pulse;
  logic [CH-1:0] pending;
  logic [CH-1:0] evt_clr;
  logic          mask_we;
  logic [CH-1:0] mask_wdata;
  logic [CH-1:0] irq_mask;
  logic          irq;

  gpio_input_conditioner #(
    .CHANNELS       (CH),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gpio_in   (gpio_in),
    .level     (level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .pending   (pending),
    .evt_clr   (evt_clr),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .irq_mask  (irq_mask),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    sel;
    logic  exp;
    string nm;
  } sb_t;

  sb_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  function automatic logic act(input int sel);
    case (sel)
      0:       return level[B];
      1:       return rise_pulse[B];
      2:       return fall_pulse[B];
      3:       return pending[B];
      4:       return irq;
      6:       return irq_mask[B];
      default: return (|(level | rise_pulse | fall_pulse | pending | irq_mask)) | irq;
    endcase
  endfunction

  task automatic exp1(input int sel, input logic v, input string nm);
    sb_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.exp = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: retire every expectation due in the current cycle
  always @(negedge clk) begin
    sb_t  e;
    logic a;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      a = act(e.sel);
      checks++;
      if (a !== e.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d actual=%0b required=%0b", e.nm, cyc, a, e.exp);
      end
    end
  end

  // The edge that samples the pin change is edge 1; level moves on edge LAT.
  task automatic edge_seq(input logic val, input logic pend7, input logic clr7);
    gpio_in[B] = val;
    for (int k = 1; k < LAT; k++) begin
      tick();
      exp1(0, ~val, "level_hold");
      exp1(1, 1'b0, "rise_early");
      exp1(2, 1'b0, "fall_early");
    end
    tick();
    exp1(0, val, "level_new");
    exp1(1, val, "rise_pulse");
    exp1(2, ~val, "fall_pulse");
    if (clr7) evt_clr[B] = 1'b1;
    tick();
    evt_clr[B] = 1'b0;
    exp1(1, 1'b0, "rise_end");
    exp1(2, 1'b0, "fall_end");
    exp1(3, pend7, "pending_after_edge");
  endtask

`ifdef GPIO_FALL_EDGE_EN
  localparam logic FALL_SETS = 1'b1;
`else
  localparam logic FALL_SETS = 1'b0;
`endif

  initial begin
    rst        = 1'b0;
    gpio_in    = '0;
    evt_clr    = '0;
    mask_we    = 1'b0;
    mask_wdata = '0;

    // Reset held while pins toggle
    repeat (6) begin
      tick();
      gpio_in = CH'({$urandom, $urandom});
      exp1(5, 1'b0, "reset_hold_zero");
    end
    gpio_in = '0;
    tick();
    rst = 1'b1;
    repeat (6) begin
      tick();
      exp1(5, 1'b0, "post_reset_zero");
    end

    // Clean press
    edge_seq(1'b1, 1'b1, 1'b0);
    exp1(4, 1'b0, "irq_masked_off");
    tick();
    exp1(4, 1'b0, "irq_masked_off2");

    // Mask load and clear
    mask_wdata    = '0;
    mask_wdata[B] = 1'b1;
    mask_we       = 1'b1;
    tick();
    mask_we = 1'b0;
    exp1(6, 1'b1, "mask_loaded");
    exp1(4, 1'b0, "irq_lag_mask");
    tick();
    exp1(4, 1'b1, "irq_set");
    exp1(6, 1'b1, "mask_hold");
    evt_clr[B] = 1'b1;
    tick();
    evt_clr[B] = 1'b0;
    exp1(3, 1'b0, "pending_cleared");
    exp1(4, 1'b1, "irq_lag_clear");
    tick();
    exp1(4, 1'b0, "irq_cleared");
    evt_clr[B] = 1'b1;
    tick();
    evt_clr[B] = 1'b0;
    exp1(3, 1'b0, "clr_on_clear_bit");

    // Release
    edge_seq(1'b0, FALL_SETS, 1'b0);
    evt_clr[B] = 1'b1;
    tick();
    evt_clr[B] = 1'b0;
    exp1(3, 1'b0, "pending_cleared_after_release");

    // Glitch of DB-1 clocks
    gpio_in[B] = 1'b1;
    for (int k = 0; k < DB - 1; k++) begin
      tick();
      exp1(0, 1'b0, "glitch_level");
      exp1(1, 1'b0, "glitch_rise");
      exp1(3, 1'b0, "glitch_pending");
    end
    gpio_in[B] = 1'b0;
    repeat (LAT + 2) begin
      tick();
      exp1(0, 1'b0, "glitch_level_after");
      exp1(1, 1'b0, "glitch_rise_after");
      exp1(3, 1'b0, "glitch_pending_after");
    end

    // Rise coinciding with clear: set wins
    edge_seq(1'b1, 1'b1, 1'b1);
    tick();
    exp1(3, 1'b1, "pending_set_wins_hold");

    // Release, then clear pending ahead of the reset test
    edge_seq(1'b0, 1'b1, 1'b0);
    evt_clr[B] = 1'b1;
    tick();
    evt_clr[B] = 1'b0;
    exp1(3, 1'b0, "pending_cleared_pre_reset");

    // Async reset mid-debounce (counter at 2 after edge 4)
    gpio_in[B] = 1'b1;
    repeat (4) begin
      tick();
      exp1(0, 1'b0, "level_midcount");
    end
    #2;
    rst = 1'b0;
    exp1(5, 1'b0, "async_reset_all_zero");
    tick();
    exp1(5, 1'b0, "async_reset_held");
    rst = 1'b1;
    edge_seq(1'b1, 1'b1, 1'b0);

    repeat (3) tick();
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d pending entries required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
